// File: rtl/multi_debounce_edge_detector.sv
// ---------------------------------------------------------------------------
// multi_debounce_edge_detector
//
// N-channel debounced edge detector for raw switch/button pins.
// Each channel has three stages:
//   1. A SYNC_STAGES-deep synchroniser.
//   2. An early-detect debounce FSM. It reports an edge on the first
//      transition it sees, then ignores the input for DB_TICKS cycles.
//   3. Moore rise/fall pulse outputs, decoded from the FSM state only.
// A global mode selects which debounced edges appear on edge_pulse.
//
// Parameters:
//   N_CH        number of independent channels (>=1)
//   SYNC_STAGES synchroniser depth per channel (>=2)
//   DB_TICKS    lockout length in clk cycles after each reported edge (>=1)
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   in          raw asynchronous inputs, one bit per channel
//   mode        edge select: 00 none, 01 rise, 10 fall, 11 both
//   level_out   debounced level per channel
//   rise_pulse  one-cycle pulse on a debounced rising edge
//   fall_pulse  one-cycle pulse on a debounced falling edge
//   edge_pulse  (rise_pulse & mode[0]) | (fall_pulse & mode[1]), per bit
//
// Optional feature, enabled when the macro EDGE_IRQ_EN is defined:
//   irq_clr     per-channel clear of the pending flag
//   irq_pending per-channel sticky flag, set by edge_pulse
//               (a set in the same cycle as a clear wins)
//   irq         OR of all irq_pending bits
// ---------------------------------------------------------------------------
module multi_debounce_edge_detector #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_TICKS    = 20
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] in,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] edge_pulse
`ifdef EDGE_IRQ_EN
    ,
    input  logic [N_CH-1:0] irq_clr,
    output logic [N_CH-1:0] irq_pending,
    output logic            irq
`endif
);

    localparam int unsigned     CNT_W    = $clog2(DB_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_TICKS - 1);

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        RISE  = 3'd1,
        HOLD1 = 3'd2,
        ONE   = 3'd3,
        FALL  = 3'd4,
        HOLD0 = 3'd5
    } state_t;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s_in;
        state_t                 state_q;
        state_t                 state_d;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic                   level;
        logic                   rise;
        logic                   fall;

        // Synchroniser: the newest sample enters at bit 0.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], in[g]};
            end
        end

        assign s_in = sync_q[SYNC_STAGES-1];

        // State and lockout-counter register.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ZERO;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Next-state logic.
        // The counter is loaded on the edge that leaves RISE/FALL.
        // The hold state then runs DB_TICKS-1 down to 0, which is
        // exactly DB_TICKS cycles.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ZERO: begin
                    if (s_in) begin
                        state_d = RISE;
                    end
                end
                RISE: begin
                    state_d = HOLD1;
                    cnt_d   = CNT_LOAD;
                end
                HOLD1: begin
                    if (cnt_q == '0) begin
                        state_d = ONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ONE: begin
                    if (!s_in) begin
                        state_d = FALL;
                    end
                end
                FALL: begin
                    state_d = HOLD0;
                    cnt_d   = CNT_LOAD;
                end
                HOLD0: begin
                    if (cnt_q == '0) begin
                        state_d = ZERO;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ZERO;
                    cnt_d   = '0;
                end
            endcase
        end

        // Moore outputs, decoded from the state register only.
        always_comb begin
            level = 1'b0;
            rise  = 1'b0;
            fall  = 1'b0;
            case (state_q)
                RISE: begin
                    level = 1'b1;
                    rise  = 1'b1;
                end
                HOLD1, ONE: begin
                    level = 1'b1;
                end
                FALL: begin
                    fall = 1'b1;
                end
                default: begin
                    level = 1'b0;
                end
            endcase
        end

        assign level_out[g]  = level;
        assign rise_pulse[g] = rise;
        assign fall_pulse[g] = fall;
    end

    // mode gates the registered pulses combinationally.
    // A change of mode therefore takes effect in the same cycle.
    assign edge_pulse = (rise_pulse & {N_CH{mode[0]}})
                      | (fall_pulse & {N_CH{mode[1]}});

`ifdef EDGE_IRQ_EN
    // Sticky pending flags. The set term is OR-ed in after the clear,
    // so a new edge in the same cycle as a clear is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_pending <= '0;
        end else begin
            irq_pending <= (irq_pending & ~irq_clr) | edge_pulse;
        end
    end

    assign irq = |irq_pending;
`endif

endmodule

// File: tb/tb_multi_debounce_edge_detector.sv
// ---------------------------------------------------------------------------
// Testbench for multi_debounce_edge_detector.
// Configuration: N_CH=4, SYNC_STAGES=2, DB_TICKS=4.
//
// Model: at each clock edge the model first takes the input value that has
// passed through the synchroniser. A channel reports an edge when both of
// these hold:
//   - that input value differs from the channel's debounced level;
//   - the lockout window opened by the channel's last edge has expired.
// The window ends DB_TICKS+2 edges after that last edge.
// ---------------------------------------------------------------------------
module tb_multi_debounce_edge_detector;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int DB = 4;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] din;
    logic [1:0]   mode;
    logic [N-1:0] level_out;
    logic [N-1:0] rise_pulse;
    logic [N-1:0] fall_pulse;
    logic [N-1:0] edge_pulse;
`ifdef EDGE_IRQ_EN
    logic [N-1:0] irq_clr;
    logic [N-1:0] irq_pending;
    logic         irq;
`endif

    multi_debounce_edge_detector #(
        .N_CH        (N),
        .SYNC_STAGES (SS),
        .DB_TICKS    (DB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in          (din),
        .mode        (mode),
        .level_out   (level_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .edge_pulse  (edge_pulse)
`ifdef EDGE_IRQ_EN
        ,
        .irq_clr     (irq_clr),
        .irq_pending (irq_pending),
        .irq         (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned  e;                  // edges since reset release
    logic [N-1:0] hist [0:4095];      // raw input sampled at each edge
    int unsigned  ready_at [N];       // first edge a channel may report again
    logic [N-1:0] m_level;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_fall;
`ifdef EDGE_IRQ_EN
    logic [N-1:0] m_pend;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e       = 0;
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
            for (int i = 0; i < N; i++) ready_at[i] = 0;
`ifdef EDGE_IRQ_EN
            m_pend = '0;
`endif
        end else begin
`ifdef EDGE_IRQ_EN
            m_pend = (m_pend & ~irq_clr) | (m_rise & {N{mode[0]}}) | (m_fall & {N{mode[1]}});
`endif
            e++;
            if (e < 4096) hist[e] = din;
            for (int i = 0; i < N; i++) begin
                logic v;
                v = (e > SS && e - SS < 4096) ? hist[e-SS][i] : 1'b0;
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (e >= ready_at[i] && v != m_level[i]) begin
                    m_level[i] = v;
                    if (v) m_rise[i] = 1'b1;
                    else   m_fall[i] = 1'b1;
                    ready_at[i] = e + DB + 2;
                end
            end
        end
    end

    // Per-cycle compare, sampled well after the active edge.
    always @(posedge clk) begin
        #2;
        chk("level_out", 32'(level_out), 32'(m_level));
        chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
        chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
        chk("edge_pulse", 32'(edge_pulse),
            32'((m_rise & {N{mode[0]}}) | (m_fall & {N{mode[1]}})));
        chk("rise_fall_excl", 32'(rise_pulse & fall_pulse), 32'd0);
`ifdef EDGE_IRQ_EN
        chk("irq_pending", 32'(irq_pending), 32'(m_pend));
        chk("irq", 32'(irq), 32'(|m_pend));
`endif
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    int nr, nf, ne, r_at, f_at, r0_at, r3_at, n0, n3, n1r, n1f, cnt;
    logic found;
    int exp_edge [4] = '{0, 1, 1, 2};
    logic [N-1:0] bounce [4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};

    initial begin
        reset_n = 1'b0;
        din     = '0;
        mode    = 2'b11;
`ifdef EDGE_IRQ_EN
        irq_clr = '0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_level", 32'(level_out), 32'd0);
        chk("reset_rise", 32'(rise_pulse), 32'd0);
        chk("reset_fall", 32'(fall_pulse), 32'd0);
        chk("reset_edge", 32'(edge_pulse), 32'd0);

        // Rise latency: in[0] goes high before edge 1.
        @(negedge clk);
        reset_n = 1'b1;
        din     = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k < 3) begin
                chk("lat_rise_early", 32'(rise_pulse), 32'd0);
                chk("lat_level_early", 32'(level_out), 32'd0);
            end else if (k == 3) begin
                chk("lat_rise_e3", 32'(rise_pulse), 32'h1);
                chk("lat_edge_e3", 32'(edge_pulse), 32'h1);
                chk("lat_level_e3", 32'(level_out), 32'h1);
                chk("lat_fall_e3", 32'(fall_pulse), 32'd0);
            end else begin
                chk("lat_rise_e4", 32'(rise_pulse), 32'd0);
                chk("lat_edge_e4", 32'(edge_pulse), 32'd0);
                chk("lat_level_e4", 32'(level_out), 32'h1);
            end
        end

        // Bounce rejection on channel 0.
        @(negedge clk);
        din = 4'b0000;
        repeat (14) @(negedge clk);
        nr = 0; nf = 0; r_at = -1; f_at = -1;
        for (int j = 0; j < 20; j++) begin
            if (j > 0) @(negedge clk);
            din = (j < 4) ? bounce[j] : 4'b0000;
            @(posedge clk);
            #1;
            if (rise_pulse[0]) begin nr++; r_at = j; end
            if (fall_pulse[0]) begin nf++; f_at = j; end
        end
        chk("bounce_rise_count", 32'(nr), 32'd1);
        chk("bounce_fall_count", 32'(nf), 32'd1);
        chk("bounce_spacing", 32'(f_at - r_at), 32'd6);

        // Mode filter on channel 1.
        for (int m = 0; m < 4; m++) begin
            nr = 0; nf = 0; ne = 0;
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                if (j == 0) begin
                    mode = 2'(m);
                    din  = 4'b0010;
                end else if (j == 10) begin
                    din = 4'b0000;
                end
                @(posedge clk);
                #1;
                if (rise_pulse[1]) nr++;
                if (fall_pulse[1]) nf++;
                if (edge_pulse[1]) ne++;
            end
            chk("mode_rise_count", 32'(nr), 32'd1);
            chk("mode_fall_count", 32'(nf), 32'd1);
            chk("mode_edge_count", 32'(ne), 32'(exp_edge[m]));
        end

        // Channel independence: ch1 high through reset; ch0 and ch3 rise together.
        @(negedge clk);
        reset_n = 1'b0;
        din     = 4'b0010;
        mode    = 2'b11;
        @(negedge clk);
        n0 = 0; n3 = 0; n1r = 0; n1f = 0; r0_at = -1; r3_at = -2;
        for (int j = 0; j < 22; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 0) reset_n = 1'b1;
            if (j == 2) din = 4'b1011;
            @(posedge clk);
            #1;
            if (rise_pulse[0]) begin n0++; r0_at = j; end
            if (rise_pulse[3]) begin n3++; r3_at = j; end
            if (rise_pulse[1]) n1r++;
            if (fall_pulse[1]) n1f++;
        end
        chk("indep_same_cycle", 32'(r0_at), 32'(r3_at));
        chk("indep_ch0_count", 32'(n0), 32'd1);
        chk("indep_ch3_count", 32'(n3), 32'd1);
        chk("indep_ch1_rise", 32'(n1r), 32'd1);
        chk("indep_ch1_fall", 32'(n1f), 32'd0);

        // Reset in the middle of HOLD1 on channel 2.
        @(negedge clk);
        din   = 4'b1111;
        found = 1'b0;
        for (int j = 0; j < 10 && !found; j++) begin
            @(posedge clk);
            #1;
            if (rise_pulse[2]) found = 1'b1;
        end
        chk("hold_rise_seen", 32'(found), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midhold_level2", 32'(level_out[2]), 32'd0);
        chk("midhold_level_all", 32'(level_out), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cnt   = 0;
        found = 1'b0;
        for (int j = 1; j <= 10 && !found; j++) begin
            @(posedge clk);
            #1;
            if (rise_pulse[2]) begin found = 1'b1; cnt = j; end
        end
        chk("midhold_rerise_edges", 32'(cnt), 32'd3);

`ifdef EDGE_IRQ_EN
        // Pending flags: all channels were set by the rise after reset release.
        @(posedge clk);
        #1;
        chk("irq_pend_after_rise", 32'(irq_pending), 32'hF);
        @(negedge clk);
        irq_clr = 4'b1110;
        @(negedge clk);
        irq_clr = '0;
        chk("irq_only_ch0", 32'(irq_pending), 32'h1);
        din   = 4'b1110;
        found = 1'b0;
        for (int j = 0; j < 20 && !found; j++) begin
            @(posedge clk);
            #1;
            if (fall_pulse[0]) found = 1'b1;
        end
        chk("irq_fall_seen", 32'(found), 32'd1);
        @(negedge clk);
        irq_clr = 4'b0001;
        @(posedge clk);
        #1;
        chk("irq_set_wins_pend", 32'(irq_pending[0]), 32'd1);
        chk("irq_set_wins_irq", 32'(irq), 32'd1);
        @(negedge clk);
        irq_clr = '0;
        repeat (2) @(negedge clk);
        irq_clr = 4'b0001;
        @(posedge clk);
        #1;
        chk("irq_clear_pend", 32'(irq_pending), 32'd0);
        chk("irq_clear_irq", 32'(irq), 32'd0);
        @(negedge clk);
        irq_clr = '0;
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_debounce_edge_detector.md
Name: multi_debounce_edge_detector

Overview:
- Parametrised N-channel successor to the single-input Moore edge detector.
- Each channel has three stages:
  - a synchroniser;
  - an early-detect debounce FSM, which reports an edge on the first transition and then ignores the input for a lockout window;
  - Moore rise/fall pulse outputs.
- A global mode selects which edges drive edge_pulse.
- Sits between raw switch/button pins and control logic.

Parameters:
- N_CH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- DB_TICKS, 20, lockout length in clk cycles after each reported edge (>=1). Counter width is derived as $clog2(DB_TICKS+1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  N_CH  raw asynchronous inputs.
- mode  input  2  edge select: 00 none, 01 rise, 10 fall, 11 both.
- level_out  output  N_CH  debounced level per channel.
- rise_pulse  output  N_CH  one-cycle pulse on debounced rising edge.
- fall_pulse  output  N_CH  one-cycle pulse on debounced falling edge.
- edge_pulse  output  N_CH  rise_pulse&mode[0] | fall_pulse&mode[1], per bit.

Behaviour:
- Single clock domain. reset_n is asynchronous, active-low.
- While reset_n=0:
  - all sync flops = 0;
  - all FSMs in ZERO, all counters = 0;
  - level_out = 0, rise_pulse = 0, fall_pulse = 0, edge_pulse = 0.
- Synchroniser: in[i] passes through SYNC_STAGES flops to give s_in[i].
- Per-channel Moore FSM, outputs decoded from state only:
  - ZERO: level 0. s_in=1 -> RISE; else stay.
  - RISE: level 1, rise_pulse 1. Counter loaded DB_TICKS-1. -> HOLD1.
  - HOLD1: level 1. s_in ignored. Counter decrements; at 0 -> ONE. Occupies exactly DB_TICKS cycles.
  - ONE: level 1. s_in=0 -> FALL; else stay.
  - FALL: level 0, fall_pulse 1. Counter loaded DB_TICKS-1. -> HOLD0.
  - HOLD0: level 0. s_in ignored. Exactly DB_TICKS cycles, then -> ZERO.
  - Illegal/unused encoding -> ZERO.
- Latency: with in[i] rising before clk edge 1, the channel enters RISE at edge SYNC_STAGES+1. rise_pulse and level_out go high together, and the pulse lasts exactly one cycle.
- Minimum spacing:
  - rise_pulse at cycle t means the earliest possible fall_pulse is cycle t+DB_TICKS+2.
  - The same spacing applies fall to rise.
- Bounces inside HOLD1/HOLD0 are discarded. After the hold, the FSM acts on the current s_in level only; no edge is queued.
- rise_pulse and fall_pulse are never both high on one channel in the same cycle.
- mode is applied combinationally to the registered pulses.
  - A mode change affects edge_pulse in the same cycle.
  - rise_pulse and fall_pulse are unaffected by mode.
- Channels are fully independent. Simultaneous events on several channels produce pulses in the same cycle.
- If in[i]=1 at reset release, a rise_pulse is generated after SYNC_STAGES+1 edges (intended power-on behaviour).
- Reset asserted mid-operation, including in any hold state, forces the reset values immediately with no wait for clk.

Optional Feature:
- Macro: EDGE_IRQ_EN.
- When defined, adds three ports:
  - irq_clr (input, N_CH);
  - irq_pending (output, N_CH, registered);
  - irq (output, 1) = OR of irq_pending.
- Pending behaviour per bit:
  - irq_pending[i] sets on edge_pulse[i] and clears on irq_clr[i].
  - Simultaneous set and clear: set wins.
  - Reset value 0.
- When undefined, these ports and registers do not exist. Behaviour is otherwise identical.

Test Plan:
- Rise latency. SYNC_STAGES=2, DB_TICKS=4, mode=11, in[0] 0->1 before edge 1 and held.
  - Required: rise_pulse[0], edge_pulse[0] and level_out[0] go high after edge 3.
  - rise_pulse[0] and edge_pulse[0] drop after edge 4; level_out[0] stays 1.
  - No other channel toggles.
- Bounce rejection. in[0] rises, then toggles every cycle for 3 cycles, ending at 0.
  - Required: exactly one rise_pulse[0].
  - fall_pulse[0] occurs exactly DB_TICKS+2 = 6 cycles after that rise_pulse.
- Mode filter. Toggle in[1] with mode = 00, 01, 10, 11 in turn.
  - Required: edge_pulse[1] shows none / rise only / fall only / both.
  - rise_pulse[1] and fall_pulse[1] appear in every case.
- Channel independence. in[0] and in[3] rise on the same cycle; in[1] held at 1.
  - Required: rise_pulse[0] and rise_pulse[3] in the same cycle.
  - Channel 1 emits its single power-on rise only.
- Reset mid-hold. Drive reset_n=0 two cycles into HOLD1 on channel 2 while in[2] stays 1.
  - Required: level_out[2]=0 immediately.
  - After release, a new rise_pulse[2] after 3 edges.
- IRQ (EDGE_IRQ_EN). After a rise_pulse[0] has set irq_pending[0], pulse irq_clr[0] in the same cycle as a second edge on channel 0.
  - Required: irq_pending[0] stays 1 and irq stays 1.
  - A later irq_clr[0] alone clears both to 0.
